// File: rtl/midi_pkg.sv
// Shared constants and state types for the MIDI input block: status nibbles,
// pitch-bend centre, the all-notes-off controller and the FSM encodings.
package midi_pkg;

  localparam logic [3:0] ST_NOTE_OFF   = 4'h8;
  localparam logic [3:0] ST_NOTE_ON    = 4'h9;
  localparam logic [3:0] ST_CTRL       = 4'hB;
  localparam logic [3:0] ST_PROG       = 4'hC;
  localparam logic [3:0] ST_CHAN_PRESS = 4'hD;
  localparam logic [3:0] ST_BEND       = 4'hE;

  localparam logic [13:0] BEND_CENTRE      = 14'h2000;
  localparam logic [6:0]  CC_ALL_NOTES_OFF = 7'd123;

  typedef enum logic [1:0] {
    NO_STATUS,
    WAIT_D1,
    WAIT_D2
  } parser_state_t;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP,
    RX_WAIT_HIGH
  } rx_state_t;

  // Program change and channel pressure carry a single data byte.
  function automatic logic is_one_data_msg(input logic [3:0] hi);
    return (hi == ST_PROG) || (hi == ST_CHAN_PRESS);
  endfunction

endpackage

// File: rtl/midi_uart_rx.sv
// 8N1 serial receiver for the MIDI line: synchronises rx, validates the start
// bit at mid-bit, samples data LSB first and flags a low stop bit.
module midi_uart_rx
  import midi_pkg::*;
#(
  parameter int BIT_CLKS = 1024
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  output logic [7:0] data_byte,
  output logic       byte_valid,
  output logic       frame_err
);

  localparam int             CW        = $clog2(BIT_CLKS) + 1;
  localparam logic [CW-1:0]  FULL_LAST = CW'(BIT_CLKS - 1);
  localparam logic [CW-1:0]  HALF_LAST = CW'(BIT_CLKS / 2 - 1);

  logic          r_rx_s1;
  logic          r_rx_s2;
  logic          r_rx_prev;
  rx_state_t     r_state;
  logic [CW-1:0] r_cnt;
  logic [2:0]    r_bit;
  logic [7:0]    r_shift;
  logic [7:0]    r_byte;
  logic          r_valid;
  logic          r_ferr;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rx_s1   <= 1'b1;
      r_rx_s2   <= 1'b1;
      r_rx_prev <= 1'b1;
      r_state   <= RX_IDLE;
      r_cnt     <= '0;
      r_bit     <= '0;
      r_shift   <= '0;
      r_byte    <= '0;
      r_valid   <= 1'b0;
      r_ferr    <= 1'b0;
    end else begin
      r_rx_s1   <= rx;
      r_rx_s2   <= r_rx_s1;
      r_rx_prev <= r_rx_s2;
      r_valid   <= 1'b0;
      r_ferr    <= 1'b0;
      case (r_state)
        RX_IDLE: begin
          if (r_rx_prev && !r_rx_s2) begin
            r_state <= RX_START;
            r_cnt   <= '0;
          end
        end
        RX_START: begin
          // A glitch that is high again by mid-bit is not a start bit.
          if (r_cnt == HALF_LAST) begin
            r_cnt   <= '0;
            r_bit   <= '0;
            r_state <= r_rx_s2 ? RX_IDLE : RX_DATA;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        RX_DATA: begin
          if (r_cnt == FULL_LAST) begin
            r_cnt   <= '0;
            r_shift <= {r_rx_s2, r_shift[7:1]};
            r_bit   <= r_bit + 1'b1;
            if (r_bit == 3'd7) begin
              r_state <= RX_STOP;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        RX_STOP: begin
          if (r_cnt == FULL_LAST) begin
            r_cnt <= '0;
            if (r_rx_s2) begin
              r_byte  <= r_shift;
              r_valid <= 1'b1;
              r_state <= RX_IDLE;
            end else begin
              r_ferr  <= 1'b1;
              r_state <= RX_WAIT_HIGH;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        RX_WAIT_HIGH: begin
          if (r_rx_s2) begin
            r_state <= RX_IDLE;
          end
        end
        default: r_state <= RX_IDLE;
      endcase
    end
  end

  assign data_byte  = r_byte;
  assign byte_valid = r_valid;
  assign frame_err  = r_ferr;

endmodule

// File: rtl/midi_in.sv
// MIDI input: serial receiver plus a running-status message parser that
// tracks the current note, its velocity and the pitch wheel on one channel.
module midi_in
  import midi_pkg::*;
#(
  parameter logic [3:0] CHANNEL  = 4'd0,
  parameter int         BIT_CLKS = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rx,
  output logic [6:0]  note,
  output logic [13:0] bend,
  output logic [6:0]  velocity,
  output logic        gate,
  output logic        frame_err
);

  logic [7:0] w_byte;
  logic       w_byte_valid;
  logic       w_frame_err;

  midi_uart_rx #(
    .BIT_CLKS(BIT_CLKS)
  ) u_rx (
    .clk       (clk),
    .reset     (reset),
    .rx        (rx),
    .data_byte (w_byte),
    .byte_valid(w_byte_valid),
    .frame_err (w_frame_err)
  );

  parser_state_t r_pstate;
  logic [7:0]    r_status;
  logic [6:0]    r_d1;
  logic [6:0]    r_note;
  logic [6:0]    r_vel;
  logic [13:0]   r_bend;
  logic          r_gate;

  logic          w_realtime;
  logic          w_system;
  logic          w_complete;
  logic [6:0]    w_d1;
  logic [6:0]    w_d2;
  logic [6:0]    w_note_nxt;
  logic [6:0]    w_vel_nxt;
  logic [13:0]   w_bend_nxt;

  assign w_realtime = (w_byte[7:3] == 5'b11111);
  assign w_system   = (w_byte[7:3] == 5'b11110);
  assign w_d1       = (r_pstate == WAIT_D1) ? w_byte[6:0] : r_d1;
  assign w_d2       = w_byte[6:0];
  assign w_complete = w_byte_valid && !w_byte[7] &&
                      (((r_pstate == WAIT_D1) && is_one_data_msg(r_status[7:4])) ||
                       (r_pstate == WAIT_D2));

  always_comb begin
    w_note_nxt = r_note;
    w_vel_nxt  = r_vel;
    w_bend_nxt = r_bend;
    if (w_complete && (r_status[3:0] == CHANNEL)) begin
      case (r_status[7:4])
        ST_NOTE_ON: begin
          if (w_d2 != 7'd0) begin
            if (w_d1 != 7'd0) begin
              w_note_nxt = w_d1;
              w_vel_nxt  = w_d2;
            end
          end else if (w_d1 == r_note) begin
            w_note_nxt = 7'd0;
            w_vel_nxt  = 7'd0;
          end
        end
        ST_NOTE_OFF: begin
          if (w_d1 == r_note) begin
            w_note_nxt = 7'd0;
            w_vel_nxt  = 7'd0;
          end
        end
        ST_BEND: w_bend_nxt = {w_d2, w_d1};
        ST_CTRL: begin
          if (w_d1 == CC_ALL_NOTES_OFF) begin
            w_note_nxt = 7'd0;
            w_vel_nxt  = 7'd0;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pstate <= NO_STATUS;
      r_status <= '0;
      r_d1     <= '0;
      r_note   <= '0;
      r_vel    <= '0;
      r_bend   <= BEND_CENTRE;
      r_gate   <= 1'b0;
    end else begin
      r_note <= w_note_nxt;
      r_vel  <= w_vel_nxt;
      r_bend <= w_bend_nxt;
      r_gate <= (w_note_nxt != 7'd0);
      // Real-time bytes may appear anywhere and must not disturb a message.
      if (w_byte_valid && !w_realtime) begin
        if (w_system) begin
          r_status <= '0;
          r_pstate <= NO_STATUS;
        end else if (w_byte[7]) begin
          r_status <= w_byte;
          r_pstate <= WAIT_D1;
        end else begin
          case (r_pstate)
            WAIT_D1: begin
              r_d1 <= w_byte[6:0];
              if (!is_one_data_msg(r_status[7:4])) begin
                r_pstate <= WAIT_D2;
              end
            end
            WAIT_D2: r_pstate <= WAIT_D1;
            default: ;
          endcase
        end
      end
    end
  end

  assign note      = r_note;
  assign velocity  = r_vel;
  assign bend      = r_bend;
  assign gate      = r_gate;
  assign frame_err = w_frame_err;

endmodule
